tdc_shot_seq: RTL and testbench
===============================

Name: tdc_shot_seq

Overview:
- Shot sequencer in front of tdc_top. Runs one measurement frame of N laser shots.
- Per shot: resets the TDC, issues a TDC_start pulse, then forwards the TDC output stream downstream with a shot index tag.
- A shot closes on the TDC last beat or on window timeout.
- Raises a frame-done pulse and keeps a sticky timeout flag for the core logic.

Parameters:
- RST_CYC, 2, cycles tdc_rst_n is held low before each shot (1..15).
- START_CYC, 20, cycles tdc_start is held high per shot (1..255).
- WIN_CYC, 1024, measurement window in cycles counted from tdc_start falling (2..65535).
- SHOT_W, 8, width of the shot count and shot index.

Ports:
- clk_i  in  1  logic clock, 250 MHz domain of tdc_top
- rst  in  1  asynchronous reset, active low
- go  in  1  1-cycle frame request; ignored while busy
- abort  in  1  level; forces return to IDLE
- cfg_shots  in  SHOT_W  shots per frame, latched on accepted go; 0 is treated as 1
- tdc_rst_n  out  1  TDC reset, active low
- tdc_start  out  1  TDC start pulse
- tdc_data  in  15  TDC_Odata
- tdc_int  in  5  TDC_Oint
- tdc_num  in  2  TDC_Onum
- tdc_last  in  1  TDC_Olast
- tdc_valid  in  1  TDC_Ovalid
- tdc_ready  out  1  TDC_Oready
- m_data  out  15  forwarded data
- m_int  out  5  forwarded intensity
- m_num  out  2  forwarded valid-count
- m_shot  out  SHOT_W  index of the current shot (0-based)
- m_last  out  1  last beat of the shot
- m_flast  out  1  last beat of the frame
- m_valid  out  1  downstream valid
- m_ready  in  1  downstream ready
- busy  out  1  high in any state except IDLE
- frame_done  out  1  1-cycle pulse at frame end
- err_timeout  out  1  sticky: some shot hit window expiry; cleared on accepted go

Behaviour:
- Reset values:
  - tdc_rst_n=0; tdc_start=0; busy=0; frame_done=0; err_timeout=0.
  - Shot counter 0; FSM in IDLE.
  - m_valid=0 and tdc_ready=0, since both are gated by state.
- From the first clk_i after reset release, IDLE drives tdc_rst_n=1.
- FSM states: IDLE, TRST, START, WIN, NEXT, DONE.
- IDLE:
  - go=1 with abort=0 latches shots_q=max(cfg_shots,1).
  - Clears shot_cnt and err_timeout, then goes to TRST.
- TRST: tdc_rst_n=0 for exactly RST_CYC cycles, then START.
- START: tdc_start=1 for exactly START_CYC cycles, then WIN. tdc_rst_n is 1.
- WIN: window counter loads 0 on entry and increments every cycle.
- Passthrough in WIN (combinational):
  - m_valid = tdc_valid and tdc_ready = m_ready.
  - m_data, m_int, m_num and m_last pass straight through from the TDC side.
  - m_shot = shot_cnt.
  - m_flast = tdc_last & (shot_cnt == shots_q-1).
  - Outside WIN, m_valid=0 and tdc_ready=0.
- A handshake is tdc_valid & m_ready in WIN.
- Shot end:
  - A handshake with tdc_last=1 goes to NEXT.
  - Otherwise, when the window counter reaches WIN_CYC-1, set err_timeout and go to NEXT.
  - If both happen in the same cycle, the last beat is accepted and err_timeout is not set.
- NEXT (1 cycle):
  - If shot_cnt == shots_q-1, go to DONE.
  - Otherwise shot_cnt++ and go to TRST.
- DONE (1 cycle): frame_done=1, then IDLE.
- Timing: frame_done fires 2 cycles after the last-beat handshake.
- abort=1 in any state:
  - Next state is IDLE; tdc_start drops to 0 next cycle.
  - No frame_done; err_timeout is kept.
  - A beat in flight in that cycle may still handshake.
- go while busy is ignored. go with abort both high is ignored.
- All state registers use asynchronous reset on rst; there is no other reset path.

Test Plan:
- Single shot:
  - Stimulus: cfg_shots=1, go; model returns 2 beats (data 0x0123, int 5; then data 0x0456, int 9, last).
  - Required: tdc_rst_n low 2 cycles, tdc_start high 20 cycles, both beats forwarded with m_shot=0.
  - Required: m_flast only on beat 2, frame_done 2 cycles later, err_timeout=0.
- Multi-shot:
  - Stimulus: cfg_shots=3; each shot returns 1 last beat.
  - Required: 3 TRST/START sequences, m_shot 0,1,2, m_flast only on shot 2, exactly one frame_done.
- Timeout:
  - Stimulus: cfg_shots=2; shot 0 returns nothing.
  - Required: WIN lasts 1024 cycles, err_timeout=1, shot 1 still runs, frame_done asserted, err_timeout stays 1 until next go.
- Backpressure:
  - Stimulus: m_ready low 10 cycles while tdc_valid=1.
  - Required: tdc_ready=0, no beat lost, data held stable, beat accepted on the first m_ready=1 cycle.
- Boundaries:
  - cfg_shots=0 behaves as 1.
  - Last beat handshake in window cycle WIN_CYC-1 gives no timeout.
  - go during busy has no effect.
- Abort/reset mid-frame:
  - abort in START: tdc_start=0 next cycle, IDLE, no frame_done.
  - rst low in WIN: all outputs go to reset values immediately.

Source files
------------

// File: rtl/tdc_shot_seq.sv
// Shot sequencer in front of tdc_top: runs a frame of N laser shots, resetting and
// starting the TDC per shot and forwarding its output stream tagged with the shot index.
`timescale 1ns/1ps

module tdc_shot_seq #(
    parameter int unsigned RST_CYC   = 2,
    parameter int unsigned START_CYC = 20,
    parameter int unsigned WIN_CYC   = 1024,
    parameter int unsigned SHOT_W    = 8
) (
    input  logic              clk_i,
    input  logic              rst,
    input  logic              go,
    input  logic              abort,
    input  logic [SHOT_W-1:0] cfg_shots,
    output logic              tdc_rst_n,
    output logic              tdc_start,
    input  logic [14:0]       tdc_data,
    input  logic [4:0]        tdc_int,
    input  logic [1:0]        tdc_num,
    input  logic              tdc_last,
    input  logic              tdc_valid,
    output logic              tdc_ready,
    output logic [14:0]       m_data,
    output logic [4:0]        m_int,
    output logic [1:0]        m_num,
    output logic [SHOT_W-1:0] m_shot,
    output logic              m_last,
    output logic              m_flast,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              err_timeout
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TRST  = 3'd1,
        START = 3'd2,
        WIN   = 3'd3,
        NEXT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [15:0] RST_LAST   = 16'(RST_CYC - 1);
    localparam logic [15:0] START_LAST = 16'(START_CYC - 1);
    localparam logic [15:0] WIN_LAST   = 16'(WIN_CYC - 1);

    state_t              state_q;
    logic [15:0]         cnt_q;
    logic [SHOT_W-1:0]   shots_q;
    logic [SHOT_W-1:0]   shot_cnt_q;
    logic                tdc_rst_n_q;
    logic                tdc_start_q;
    logic                busy_q;
    logic                frame_done_q;
    logic                err_timeout_q;

    logic                in_win_s;
    logic                last_shot_s;
    logic                hs_s;

    assign in_win_s    = (state_q == WIN);
    assign last_shot_s = (shot_cnt_q == (shots_q - SHOT_W'(1)));
    assign hs_s        = in_win_s & tdc_valid & m_ready;

    // The stream is only connected to the TDC while the measurement window is open.
    assign m_valid   = in_win_s & tdc_valid;
    assign tdc_ready = in_win_s & m_ready;
    assign m_data    = tdc_data;
    assign m_int     = tdc_int;
    assign m_num     = tdc_num;
    assign m_last    = tdc_last;
    assign m_shot    = shot_cnt_q;
    assign m_flast   = tdc_last & last_shot_s;

    assign tdc_rst_n   = tdc_rst_n_q;
    assign tdc_start   = tdc_start_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign err_timeout = err_timeout_q;

    // Frame sequencer; cnt_q times TRST, START and the measurement window in turn.
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= 16'd0;
            shots_q       <= SHOT_W'(1);
            shot_cnt_q    <= '0;
            tdc_rst_n_q   <= 1'b0;
            tdc_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else if (abort) begin
            state_q      <= IDLE;
            tdc_rst_n_q  <= 1'b1;
            tdc_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    tdc_rst_n_q  <= 1'b1;
                    frame_done_q <= 1'b0;
                    if (go) begin
                        shots_q       <= (cfg_shots == '0) ? SHOT_W'(1) : cfg_shots;
                        shot_cnt_q    <= '0;
                        err_timeout_q <= 1'b0;
                        cnt_q         <= 16'd0;
                        tdc_rst_n_q   <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= TRST;
                    end
                end
                TRST: begin
                    if (cnt_q == RST_LAST) begin
                        cnt_q       <= 16'd0;
                        tdc_rst_n_q <= 1'b1;
                        tdc_start_q <= 1'b1;
                        state_q     <= START;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                START: begin
                    if (cnt_q == START_LAST) begin
                        cnt_q       <= 16'd0;
                        tdc_start_q <= 1'b0;
                        state_q     <= WIN;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                WIN: begin
                    cnt_q <= cnt_q + 16'd1;
                    // An accepted last beat wins over a simultaneous window expiry.
                    if (hs_s && tdc_last) begin
                        state_q <= NEXT;
                    end else if (cnt_q == WIN_LAST) begin
                        err_timeout_q <= 1'b1;
                        state_q       <= NEXT;
                    end else begin
                        state_q <= WIN;
                    end
                end
                NEXT: begin
                    if (last_shot_s) begin
                        frame_done_q <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        shot_cnt_q  <= shot_cnt_q + SHOT_W'(1);
                        cnt_q       <= 16'd0;
                        tdc_rst_n_q <= 1'b0;
                        state_q     <= TRST;
                    end
                end
                DONE: begin
                    frame_done_q <= 1'b0;
                    busy_q       <= 1'b0;
                    tdc_rst_n_q  <= 1'b1;
                    state_q      <= IDLE;
                end
                default: begin
                    frame_done_q <= 1'b0;
                    busy_q       <= 1'b0;
                    tdc_rst_n_q  <= 1'b1;
                    tdc_start_q  <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_shot_seq.sv
// Randomized scoreboard bench for tdc_shot_seq: a TDC source model feeds planned beats,
// a monitor pops expected beats on every downstream handshake and checks frame timing.
`timescale 1ns/1ps

module tb_tdc_shot_seq;

    localparam int RST_CYC   = 2;
    localparam int START_CYC = 20;
    localparam int WIN_CYC   = 1024;
    localparam int SHOT_W    = 8;
    localparam int MAXS      = 8;
    localparam int MAXB      = 4;

    logic              clk_i = 1'b0;
    logic              rst;
    logic              go;
    logic              abort;
    logic [SHOT_W-1:0] cfg_shots;
    logic              tdc_rst_n;
    logic              tdc_start;
    logic [14:0]       tdc_data;
    logic [4:0]        tdc_int;
    logic [1:0]        tdc_num;
    logic              tdc_last;
    logic              tdc_valid;
    logic              tdc_ready;
    logic [14:0]       m_data;
    logic [4:0]        m_int;
    logic [1:0]        m_num;
    logic [SHOT_W-1:0] m_shot;
    logic              m_last;
    logic              m_flast;
    logic              m_valid;
    logic              m_ready;
    logic              busy;
    logic              frame_done;
    logic              err_timeout;

    tdc_shot_seq #(
        .RST_CYC(RST_CYC), .START_CYC(START_CYC), .WIN_CYC(WIN_CYC), .SHOT_W(SHOT_W)
    ) dut (
        .clk_i(clk_i), .rst(rst), .go(go), .abort(abort), .cfg_shots(cfg_shots),
        .tdc_rst_n(tdc_rst_n), .tdc_start(tdc_start), .tdc_data(tdc_data),
        .tdc_int(tdc_int), .tdc_num(tdc_num), .tdc_last(tdc_last),
        .tdc_valid(tdc_valid), .tdc_ready(tdc_ready), .m_data(m_data), .m_int(m_int),
        .m_num(m_num), .m_shot(m_shot), .m_last(m_last), .m_flast(m_flast),
        .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .frame_done(frame_done),
        .err_timeout(err_timeout)
    );

    initial forever #2 clk_i = ~clk_i;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int fd_cnt = 0;
    int st_cnt = 0;
    int pop_cyc = -1;
    int flast_cyc = -1;
    bit pchk_en = 1'b0;
    int rdy_mode = 1;
    bit bp_rdy = 1'b0;

    logic [31:0] sb_q[$];

    int          plan_nb[MAXS];
    int          plan_dly[MAXS];
    logic [14:0] plan_data[MAXS][MAXB];
    logic [4:0]  plan_int[MAXS][MAXB];
    logic [1:0]  plan_num[MAXS][MAXB];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired or unexpected event (cycle %0d)", nm, cyc);
    endtask

    initial forever @(posedge clk_i) cyc++;

    // Downstream ready: random, held high, or under direct control of a test.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            case (rdy_mode)
                0:       m_ready = ($urandom_range(0, 3) != 0);
                1:       m_ready = 1'b1;
                default: m_ready = bp_rdy;
            endcase
        end
    end

    // Monitor: scoreboard pops, handshake rules, pulse widths and frame_done latency.
    initial begin
        int  rl = 0;
        int  sl = 0;
        logic sp = 1'b0;
        logic [31:0] exp_beat;
        forever begin
            @(negedge clk_i);
            if (rst) begin
                if (m_valid) begin
                    chk1("m_valid_implies_tdc_valid", tdc_valid, 1'b1);
                    chk1("tdc_ready_follows_m_ready", tdc_ready, m_ready);
                end
                if (tdc_valid && !m_ready) chk1("tdc_ready_low_when_blocked", tdc_ready, 1'b0);
                if (m_valid && m_ready) begin
                    if (sb_q.size() == 0) begin
                        fail_now("unexpected_beat");
                    end else begin
                        exp_beat = sb_q.pop_front();
                        chk("beat", {m_data, m_int, m_num, m_shot, m_last, m_flast}, exp_beat);
                    end
                    pop_cyc = cyc;
                    if (m_flast) flast_cyc = cyc;
                end
                if (frame_done) begin
                    fd_cnt++;
                    if (flast_cyc >= 0) chk("frame_done_latency", cyc - flast_cyc, 2);
                    flast_cyc = -1;
                end
            end
            if (!tdc_rst_n) rl++;
            else begin
                if (rl != 0 && pchk_en) chk("tdc_rst_n_low_cycles", rl, RST_CYC);
                rl = 0;
            end
            if (tdc_start) sl++;
            else begin
                if (sl != 0 && pchk_en) chk("tdc_start_high_cycles", sl, START_CYC);
                sl = 0;
            end
            if (tdc_start && !sp) st_cnt++;
            sp = tdc_start;
        end
    end

    initial begin
        repeat (90000) @(posedge clk_i);
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    task automatic wait_win(output bit ok);
        logic prev = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_i);
            if (prev && !tdc_start) begin
                ok = 1'b1;
                break;
            end
            prev = tdc_start;
        end
        if (!ok) fail_now("wait_window_open");
    endtask

    task automatic present(input int s, input int b);
        tdc_valid = 1'b1;
        tdc_data  = plan_data[s][b];
        tdc_int   = plan_int[s][b];
        tdc_num   = plan_num[s][b];
        tdc_last  = (b == plan_nb[s] - 1);
    endtask

    task automatic await_hs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_i);
            if (tdc_valid && tdc_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk_i);
        #1;
        if (!ok) fail_now("beat_handshake");
    endtask

    task automatic drive_shots(input int n);
        bit ok;
        int gap;
        int cnt;
        for (int s = 0; s < n; s++) begin
            wait_win(ok);
            if (!ok) return;
            if (plan_nb[s] == 0) begin
                cnt = 0;
                for (int i = 0; i < WIN_CYC + 50; i++) begin
                    @(negedge clk_i);
                    cnt++;
                    if (!tdc_rst_n || !busy) break;
                end
                chk("timeout_shot_length", cnt, (s == n - 1) ? WIN_CYC + 2 : WIN_CYC + 1);
            end else begin
                repeat (plan_dly[s] + 1) @(posedge clk_i);
                #1;
                for (int b = 0; b < plan_nb[s]; b++) begin
                    if (b > 0) begin
                        gap = $urandom_range(0, 2);
                        if (gap > 0) begin
                            tdc_valid = 1'b0;
                            repeat (gap) @(posedge clk_i);
                            #1;
                        end
                    end
                    present(s, b);
                    await_hs(ok);
                    if (!ok) return;
                end
                tdc_valid = 1'b0;
                tdc_last  = 1'b0;
            end
        end
    endtask

    task automatic go_frame(input int cfg);
        @(posedge clk_i);
        #1;
        go = 1'b1;
        cfg_shots = SHOT_W'(cfg);
        @(posedge clk_i);
        #1;
        go = 1'b0;
        @(negedge clk_i);
        chk1("busy_after_go", busy, 1'b1);
        chk1("err_timeout_cleared_on_go", err_timeout, 1'b0);
        chk1("tdc_rst_n_low_after_go", tdc_rst_n, 1'b0);
    endtask

    task automatic run_frame(input int cfg, input int go_mid);
        int n;
        int fd0;
        int st0;
        bit exp_to;
        bit idle;
        logic lst;
        n = (cfg == 0) ? 1 : cfg;
        exp_to = 1'b0;
        for (int s = 0; s < n; s++) begin
            if (plan_nb[s] == 0) exp_to = 1'b1;
            for (int b = 0; b < plan_nb[s]; b++) begin
                lst = (b == plan_nb[s] - 1);
                sb_q.push_back({plan_data[s][b], plan_int[s][b], plan_num[s][b],
                                SHOT_W'(s), lst, lst & (s == n - 1)});
            end
        end
        fd0 = fd_cnt;
        st0 = st_cnt;
        go_frame(cfg);
        fork
            drive_shots(n);
            if (go_mid > 0) begin
                repeat (go_mid) @(posedge clk_i);
                #1;
                go = 1'b1;
                cfg_shots = SHOT_W'(7);
                @(posedge clk_i);
                #1;
                go = 1'b0;
                @(negedge clk_i);
                chk1("busy_after_ignored_go", busy, 1'b1);
            end
        join
        idle = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk_i);
            if (!busy) begin
                idle = 1'b1;
                break;
            end
        end
        if (!idle) fail_now("frame_end");
        chk("frame_done_count", fd_cnt - fd0, 1);
        chk("start_pulses", st_cnt - st0, n);
        chk1("err_timeout", err_timeout, exp_to);
        chk("scoreboard_drained", sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic rand_plan(input int n);
        for (int s = 0; s < MAXS; s++) begin
            plan_nb[s]  = (s < n) ? int'($urandom_range(1, 3)) : 0;
            plan_dly[s] = $urandom_range(0, 5);
            for (int b = 0; b < MAXB; b++) begin
                plan_data[s][b] = 15'($urandom);
                plan_int[s][b]  = 5'($urandom);
                plan_num[s][b]  = 2'($urandom);
            end
        end
    endtask

    initial begin
        bit ok;
        int fd0;
        int st0;
        int exp_pop;
        int cfg;
        rst = 1'b0; go = 1'b0; abort = 1'b0; cfg_shots = '0;
        tdc_valid = 1'b1; tdc_last = 1'b0; tdc_data = 15'd0; tdc_int = 5'd0; tdc_num = 2'd0;

        repeat (3) @(negedge clk_i);
        chk1("rst_tdc_rst_n", tdc_rst_n, 1'b0);
        chk1("rst_tdc_start", tdc_start, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_frame_done", frame_done, 1'b0);
        chk1("rst_err_timeout", err_timeout, 1'b0);
        chk1("rst_m_valid", m_valid, 1'b0);
        chk1("rst_tdc_ready", tdc_ready, 1'b0);
        tdc_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk_i);
        chk1("idle_tdc_rst_n_high", tdc_rst_n, 1'b1);
        @(negedge clk_i);
        pchk_en = 1'b1;
        rdy_mode = 0;

        // Single shot with two beats.
        rand_plan(1);
        plan_nb[0] = 2; plan_dly[0] = 3;
        plan_data[0][0] = 15'h0123; plan_int[0][0] = 5'd5; plan_num[0][0] = 2'd1;
        plan_data[0][1] = 15'h0456; plan_int[0][1] = 5'd9; plan_num[0][1] = 2'd2;
        run_frame(1, 0);

        // Three shots, one last beat each.
        rand_plan(3);
        for (int s = 0; s < 3; s++) plan_nb[s] = 1;
        run_frame(3, 0);

        // Shot 0 times out; an ignored go arrives while shot 1 runs.
        rand_plan(2);
        plan_nb[0] = 0; plan_nb[1] = 1; plan_dly[1] = 200;
        run_frame(2, 1100);

        // cfg_shots of zero runs one shot.
        rand_plan(1);
        run_frame(0, 0);

        // Last beat accepted in the final window cycle.
        rdy_mode = 1;
        rand_plan(1);
        plan_nb[0] = 1; plan_dly[0] = WIN_CYC - 2;
        run_frame(1, 0);

        // Backpressure for 10 cycles with a beat waiting.
        rdy_mode = 2; bp_rdy = 1'b0;
        rand_plan(1);
        plan_nb[0] = 1; plan_dly[0] = 2;
        exp_pop = -2;
        fork
            run_frame(1, 0);
            begin
                ok = 1'b0;
                for (int i = 0; i < 3000; i++) begin
                    @(negedge clk_i);
                    if (m_valid) begin
                        ok = 1'b1;
                        break;
                    end
                end
                if (!ok) fail_now("bp_wait_valid");
                for (int i = 0; i < 10; i++) begin
                    if (i > 0) @(negedge clk_i);
                    chk1("bp_tdc_ready_low", tdc_ready, 1'b0);
                    chk("bp_data_stable", {17'd0, m_data}, {17'd0, plan_data[0][0]});
                end
                bp_rdy = 1'b1;
                exp_pop = cyc + 1;
            end
        join
        chk("bp_accept_cycle", pop_cyc, exp_pop);
        rdy_mode = 0;

        // Random frames.
        for (int f = 0; f < 6; f++) begin
            cfg = $urandom_range(0, 4);
            rand_plan((cfg == 0) ? 1 : cfg);
            for (int s = 0; s < MAXS; s++)
                if (plan_nb[s] != 0 && $urandom_range(0, 9) == 0) plan_nb[s] = 0;
            run_frame(cfg, 0);
        end

        // Abort in START of shot 1 after shot 0 timed out.
        pchk_en = 1'b0;
        tdc_valid = 1'b0;
        fd0 = fd_cnt;
        st0 = st_cnt;
        go_frame(2);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_i);
            if (st_cnt - st0 == 2) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("abort_wait_second_start");
        chk1("abort_pre_err_timeout", err_timeout, 1'b1);
        @(posedge clk_i); #1; abort = 1'b1;
        @(posedge clk_i); #1; abort = 1'b0;
        @(negedge clk_i);
        chk1("abort_tdc_start_low", tdc_start, 1'b0);
        chk1("abort_busy_low", busy, 1'b0);
        @(posedge clk_i); #1; go = 1'b1; abort = 1'b1;
        @(posedge clk_i); #1; go = 1'b0; abort = 1'b0;
        repeat (10) @(negedge clk_i);
        chk1("go_with_abort_ignored", busy, 1'b0);
        chk("abort_no_frame_done", fd_cnt - fd0, 0);
        chk1("abort_keeps_err_timeout", err_timeout, 1'b1);
        chk1("abort_idle_tdc_rst_n", tdc_rst_n, 1'b1);

        // Reset while a beat is presented in the window.
        rdy_mode = 2; bp_rdy = 1'b0;
        rand_plan(1);
        go_frame(1);
        wait_win(ok);
        @(posedge clk_i); #1;
        present(0, 0);
        @(negedge clk_i);
        chk1("pre_reset_m_valid", m_valid, 1'b1);
        #0.5 rst = 1'b0;
        #0.5;
        chk1("async_rst_tdc_rst_n", tdc_rst_n, 1'b0);
        chk1("async_rst_tdc_start", tdc_start, 1'b0);
        chk1("async_rst_busy", busy, 1'b0);
        chk1("async_rst_frame_done", frame_done, 1'b0);
        chk1("async_rst_err_timeout", err_timeout, 1'b0);
        chk1("async_rst_m_valid", m_valid, 1'b0);
        chk1("async_rst_tdc_ready", tdc_ready, 1'b0);
        tdc_valid = 1'b0;
        tdc_last = 1'b0;
        @(negedge clk_i);
        rst = 1'b1;
        repeat (2) @(negedge clk_i);
        pchk_en = 1'b1;
        rdy_mode = 0;

        // Frame after reset recovery.
        rand_plan(2);
        run_frame(2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
